simple_cpu_chip: RTL and testbench



---
 rtl/simple_cpu_chip.sv | 154 +++++++++++++++
 tb/tb_simple_cpu_chip.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_cpu_chip.sv
// simple_cpu_chip
//   Single-cycle 16-bit load/store processor. The instruction ROM, data RAM
//   and 8x16 register file are all internal. After reset the core fetches
//   from address 0 and executes one instruction per clock until HALT.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset (clears pc, registers, halt)
//   pc_o       current program counter
//   wb_en_o    this cycle's instruction writes a register other than R0
//   wb_addr_o  destination register of that write
//   wb_data_o  value on the write-back bus (0 when wb_en_o is low)
//   halted_o   HALT has executed; core is frozen until reset
module simple_cpu_chip #(
  parameter string INIT_FILE  = "program.hex",
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  pc_o,
  output logic        wb_en_o,
  output logic [2:0]  wb_addr_o,
  output logic [15:0] wb_data_o,
  output logic        halted_o
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLT  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LI   = 4'h8,
    OP_LW   = 4'h9,
    OP_SW   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_JMP  = 4'hD,
    OP_SLL  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Instruction ROM contents are supplied by the environment.
  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] dmem [DMEM_DEPTH];

  // Architectural state
  logic [7:0]  pc_q, pc_d;
  logic        halted_q, halted_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  // Decode / datapath
  logic [15:0] instr;
  opcode_e     op;
  logic [2:0]  rd, rs, rt;
  logic [15:0] rd_val, rs_val, rt_val;
  logic [15:0] imm6_sx, imm9_sx;
  logic [7:0]  mem_addr;
  logic [15:0] result;
  logic        wr_req;
  logic        mem_we;
  logic        run;
  logic        wb_en;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    instr    = imem[pc_q];
    op       = opcode_e'(instr[15:12]);
    rd       = instr[11:9];
    rs       = instr[8:6];
    rt       = instr[5:3];
    rd_val   = regs_q[rd];
    rs_val   = regs_q[rs];
    rt_val   = regs_q[rt];
    imm6_sx  = {{10{instr[5]}}, instr[5:0]};
    imm9_sx  = {{7{instr[8]}}, instr[8:0]};
    // Only the low 8 bits of the effective address reach the RAM.
    mem_addr = rs_val[7:0] + imm6_sx[7:0];
    result   = '0;
    wr_req   = 1'b0;
    mem_we   = 1'b0;
    pc_d     = pc_q + 8'd1;
    halted_d = halted_q;

    case (op)
      OP_NOP:  ;
      OP_ADD:  begin result = rs_val + rt_val;               wr_req = 1'b1; end
      OP_SUB:  begin result = rs_val - rt_val;               wr_req = 1'b1; end
      OP_AND:  begin result = rs_val & rt_val;               wr_req = 1'b1; end
      OP_OR:   begin result = rs_val | rt_val;               wr_req = 1'b1; end
      OP_XOR:  begin result = rs_val ^ rt_val;               wr_req = 1'b1; end
      OP_SLT:  begin
        result = {15'd0, ($signed(rs_val) < $signed(rt_val))};
        wr_req = 1'b1;
      end
      OP_ADDI: begin result = rs_val + imm6_sx;              wr_req = 1'b1; end
      OP_LI:   begin result = imm9_sx;                       wr_req = 1'b1; end
      OP_LW:   begin result = dmem[mem_addr];                wr_req = 1'b1; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rd_val == rs_val) pc_d = pc_q + 8'd1 + imm6_sx[7:0];
      OP_BNE:  if (rd_val != rs_val) pc_d = pc_q + 8'd1 + imm6_sx[7:0];
      OP_JMP:  pc_d = instr[7:0];
      OP_SLL:  begin result = rs_val << instr[3:0];          wr_req = 1'b1; end
      OP_HALT: begin pc_d = pc_q; halted_d = 1'b1; end
      default: ;
    endcase

    // Once halted (or while reset is held) nothing may change state and the
    // debug bus must read idle, even though ROM[pc] is still being decoded.
    run = rst_n && !halted_q;
    if (!run) begin
      pc_d     = pc_q;
      halted_d = halted_q;
      mem_we   = 1'b0;
    end

    wb_en  = run && wr_req && (rd != 3'd0);
    regs_d = regs_q;
    if (wb_en) regs_d[rd] = result;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      regs_q   <= regs_d;
    end
  end

  // NOTE: the data RAM has no reset; clearing a memory array would force it
  // out of RAM macros into flops, and its contents are not defined at reset.
  always_ff @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= rd_val;
  end

  assign pc_o      = pc_q;
  assign halted_o  = halted_q;
  assign wb_en_o   = wb_en;
  assign wb_addr_o = rd;
  assign wb_data_o = wb_en ? result : 16'd0;

endmodule

// File: tb/tb_simple_cpu_chip.sv
// Testbench for simple_cpu_chip: loads small programs into the core's ROM,
// runs them and compares the debug outputs against an instruction-level
// model every cycle, plus literal expectations at chosen points.
module tb_simple_cpu_chip;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc_o;
  logic        wb_en_o;
  logic [2:0]  wb_addr_o;
  logic [15:0] wb_data_o;
  logic        halted_o;

  simple_cpu_chip #(.INIT_FILE("")) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_o      (pc_o),
    .wb_en_o   (wb_en_o),
    .wb_addr_o (wb_addr_o),
    .wb_data_o (wb_data_o),
    .halted_o  (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
    return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
  endfunction
  function automatic logic [15:0] enc_i(input int op, input int rd, input int rs, input int imm);
    return {op[3:0], rd[2:0], rs[2:0], imm[5:0]};
  endfunction
  function automatic logic [15:0] enc_li(input int rd, input int imm);
    return {4'h8, rd[2:0], imm[8:0]};
  endfunction
  function automatic logic [15:0] enc_jmp(input int target);
    return {4'hD, 4'h0, target[7:0]};
  endfunction
  localparam logic [15:0] HALT = 16'hF000;

  // ---------------- instruction-level model ----------------
  logic [15:0] prog  [256];
  logic [15:0] m_rom [256];
  int          m_ram [256];
  int          m_reg [8];
  int          m_pc;
  bit          m_halted;

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic int as_signed16(input int v);
    return sext(v, 16);
  endfunction

  // What the instruction at m_pc does, in ISA terms.
  task automatic model_eval(output bit we, output int wa, output int wd, output int npc,
                            output bit mwe, output int ma, output int md, output bit halt);
    int ins, op, rd, rs, rt, a, b, d, i6, i9;
    ins = int'(m_rom[m_pc]);
    op  = (ins >> 12) & 15;
    rd  = (ins >> 9) & 7;
    rs  = (ins >> 6) & 7;
    rt  = (ins >> 3) & 7;
    a   = m_reg[rs];
    b   = m_reg[rt];
    d   = m_reg[rd];
    i6  = sext(ins & 63, 6);
    i9  = sext(ins & 511, 9);
    we = 0; wa = rd; wd = 0; npc = (m_pc + 1) % 256;
    mwe = 0; ma = ((a + i6) % 256 + 256) % 256; md = d; halt = 0;
    case (op)
      1:  begin we = 1; wd = a + b; end
      2:  begin we = 1; wd = a - b; end
      3:  begin we = 1; wd = a & b; end
      4:  begin we = 1; wd = a | b; end
      5:  begin we = 1; wd = a ^ b; end
      6:  begin we = 1; wd = (as_signed16(a) < as_signed16(b)) ? 1 : 0; end
      7:  begin we = 1; wd = a + i6; end
      8:  begin we = 1; wd = i9; end
      9:  begin we = 1; wd = m_ram[ma]; end
      10: mwe = 1;
      11: if (d == a) npc = ((m_pc + 1 + i6) % 256 + 256) % 256;
      12: if (d != a) npc = ((m_pc + 1 + i6) % 256 + 256) % 256;
      13: npc = ins & 255;
      14: begin we = 1; wd = a * (1 << (ins & 15)); end
      15: begin halt = 1; npc = m_pc; end
      default: ;
    endcase
    wd = ((wd % 65536) + 65536) % 65536;
    if (rd == 0) we = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit we, mwe, halt;
    int wa, wd, npc, ma, md;
    if (!rst_n) begin
      m_pc = 0;
      m_halted = 0;
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
    end else if (!m_halted) begin
      model_eval(we, wa, wd, npc, mwe, ma, md, halt);
      if (we) m_reg[wa] = wd;
      if (mwe) m_ram[ma] = md;
      if (halt) m_halted = 1;
      m_pc = npc;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit we, mwe, halt;
    int wa, wd, npc, ma, md;
    if (chk_en) begin
      model_eval(we, wa, wd, npc, mwe, ma, md, halt);
      if (!rst_n || m_halted) we = 0;
      if (!we) wd = 0;
      check("model_pc", 32'(pc_o), 32'(m_pc));
      check("model_halted", 32'(halted_o), 32'(m_halted));
      check("model_wb_en", 32'(wb_en_o), 32'(we));
      if (we) check("model_wb_addr", 32'(wb_addr_o), 32'(wa));
      check("model_wb_data", 32'(wb_data_o), 32'(wd));
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  // Must be called with rst_n low.
  task automatic load_prog();
    for (int i = 0; i < 256; i++) begin
      m_rom[i]     = prog[i];
      dut.imem[i]  = prog[i];
    end
  endtask

  // Advance to the next falling edge (outputs of the next cycle).
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset shortly after a falling edge, then settle before sampling
  // cycle 0 (which is only visible until the next rising edge).
  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) m_ram[i] = 0;
    rst_n = 1'b0;

    // ---- Program 0: reset behaviour, NOP stepping, pc wrap ----
    clear_prog();
    prog[3]   = enc_jmp(8'hFE);
    load_prog();
    chk_en = 1'b1;
    cyc(2);
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_wb_en", 32'(wb_en_o), 32'd0);
    release_reset();
    check("p0_c0_pc", 32'(pc_o), 32'd0);
    cyc(1); check("p0_c1_pc", 32'(pc_o), 32'd1);
    cyc(1); check("p0_c2_pc", 32'(pc_o), 32'd2);
    cyc(1); check("p0_c3_pc", 32'(pc_o), 32'd3);
    cyc(1); check("p0_jmp_fe", 32'(pc_o), 32'hFE);
    cyc(1); check("p0_pc_ff", 32'(pc_o), 32'hFF);
    cyc(1); check("p0_pc_wrap", 32'(pc_o), 32'h00);

    // ---- Program 1: ALU, R0, shift, halt, mid-run reset ----
    enter_reset();
    clear_prog();
    prog[0] = enc_li(1, 5);
    prog[1] = enc_li(2, -3);
    prog[2] = enc_r(1, 3, 1, 2);    // ADD R3,R1,R2
    prog[3] = enc_r(2, 4, 2, 1);    // SUB R4,R2,R1
    prog[4] = enc_r(6, 5, 2, 1);    // SLT R5,R2,R1
    prog[5] = enc_i(7, 0, 0, 7);    // ADDI R0,R0,7
    prog[6] = enc_r(1, 7, 0, 0);    // ADD R7,R0,R0
    prog[7] = enc_i(14, 6, 1, 4);   // SLL R6,R1,4
    prog[8] = 16'h0000;
    prog[9] = HALT;
    load_prog();
    release_reset();
    check("p1_li5", 32'(wb_data_o), 32'h0005);
    cyc(3);                         // now at pc 3, mid-run
    check("p1_pre_rst_pc", 32'(pc_o), 32'd3);
    enter_reset();
    check("p1_midrst_pc", 32'(pc_o), 32'd0);
    check("p1_midrst_halted", 32'(halted_o), 32'd0);
    check("p1_midrst_wb_en", 32'(wb_en_o), 32'd0);
    release_reset();
    check("p1_c0_data", 32'(wb_data_o), 32'h0005);
    check("p1_c0_addr", 32'(wb_addr_o), 32'd1);
    cyc(1); check("p1_li_neg3", 32'(wb_data_o), 32'hFFFD);
    cyc(1); check("p1_add", 32'(wb_data_o), 32'h0002);
    cyc(1); check("p1_sub", 32'(wb_data_o), 32'hFFF8);
    cyc(1); check("p1_slt", 32'(wb_data_o), 32'h0001);
    cyc(1); check("p1_r0_wb_en", 32'(wb_en_o), 32'd0);
            check("p1_r0_wb_data", 32'(wb_data_o), 32'd0);
    cyc(1); check("p1_r0_reads0", 32'(wb_data_o), 32'd0);
            check("p1_r0_read_en", 32'(wb_en_o), 32'd1);
    cyc(1); check("p1_sll", 32'(wb_data_o), 32'h0050);
            check("p1_sll_addr", 32'(wb_addr_o), 32'd6);
    cyc(2); check("p1_halt_pc", 32'(pc_o), 32'd9);
            check("p1_halt_pre", 32'(halted_o), 32'd0);
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      check("p1_halted", 32'(halted_o), 32'd1);
      check("p1_frozen_pc", 32'(pc_o), 32'd9);
    end
    enter_reset();
    check("p1_rst_after_halt_pc", 32'(pc_o), 32'd0);
    check("p1_rst_after_halt_h", 32'(halted_o), 32'd0);
    release_reset();
    check("p1_rerun", 32'(wb_data_o), 32'h0005);

    // ---- Program 2: memory and control flow ----
    enter_reset();
    clear_prog();
    prog[0]     = enc_li(1, 12'h012);
    prog[1]     = enc_i(10, 1, 0, 3);   // SW R1,[R0+3]
    prog[2]     = enc_i(9, 2, 0, 3);    // LW R2,[R0+3]
    prog[3]     = enc_i(11, 1, 1, 2);   // BEQ R1,R1,+2
    prog[4]     = enc_li(7, 1);
    prog[5]     = enc_li(7, 2);
    prog[6]     = enc_i(12, 1, 1, 5);   // BNE R1,R1,+5 (not taken)
    prog[7]     = enc_jmp(8'h40);
    prog[8'h40] = enc_li(1, 3);
    prog[8'h41] = enc_i(7, 1, 1, -1);   // ADDI R1,R1,-1
    prog[8'h42] = enc_i(7, 3, 3, 1);    // ADDI R3,R3,1
    prog[8'h43] = enc_i(12, 1, 0, -3);  // BNE R1,R0,-3
    prog[8'h44] = HALT;
    load_prog();
    release_reset();
    check("p2_li", 32'(wb_data_o), 32'h0012);
    cyc(1); check("p2_sw_no_wb", 32'(wb_en_o), 32'd0);
    cyc(1); check("p2_lw_addr", 32'(wb_addr_o), 32'd2);
            check("p2_lw_data", 32'(wb_data_o), 32'h0012);
    cyc(1); check("p2_beq_pc", 32'(pc_o), 32'd3);
    cyc(1); check("p2_beq_taken", 32'(pc_o), 32'd6);
    cyc(1); check("p2_bne_not_taken", 32'(pc_o), 32'd7);
    cyc(1); check("p2_jmp", 32'(pc_o), 32'h40);
    cyc(8); check("p2_loop_pc", 32'(pc_o), 32'h42);
            check("p2_loop_cnt", 32'(wb_data_o), 32'd3);
            check("p2_loop_cnt_addr", 32'(wb_addr_o), 32'd3);
    cyc(1); check("p2_loop_exit_pc", 32'(pc_o), 32'h43);
    cyc(1); check("p2_halt_pc", 32'(pc_o), 32'h44);
    cyc(1); check("p2_halted", 32'(halted_o), 32'd1);
            check("p2_halt_freeze", 32'(pc_o), 32'h44);
    cyc(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
